// File: rtl/press_game_ctrl_if.sv
// Draw-engine job handshake between the game controller and the draw engine.
//   draw_req   : job valid, held until draw_ack
//   draw_item  : 0 = garbage sprite, 1 = press sprite
//   draw_erase : 1 = erase job, 0 = draw job
//   draw_pos   : job position
//   draw_ack   : one-cycle pulse from the draw engine when the job completes
// master = controller side, slave = draw-engine side.
interface press_game_ctrl_if #(
    parameter int POS_W = 3
);
    logic             draw_req;
    logic             draw_item;
    logic             draw_erase;
    logic [POS_W-1:0] draw_pos;
    logic             draw_ack;

    modport master (output draw_req, output draw_item, output draw_erase,
                    output draw_pos, input draw_ack);
    modport slave  (input draw_req, input draw_item, input draw_erase,
                    input draw_pos, output draw_ack);
endinterface

// File: rtl/press_game_ctrl.sv
// Game controller for the press/garbage game.
// Sweeps a press across NUM_POS positions on each tick, spawns garbage from
// the RNG, scores hits/misses on the (active-low) hit button, and sequences
// erase/draw jobs to the draw engine.
// Ports:
//   CLOCK_50   in   system clock, everything on posedge
//   reset_n    in   asynchronous active-low reset
//   tick       in   one-cycle pulse, advances the press
//   hit_n      in   hit button, active-low, already synchronised
//   rng        in   free-running random byte
//   draw       if   job handshake to the draw engine (master side)
//   press_pos  out  current press position
//   garb_valid out  garbage present
//   garb_pos   out  garbage position
//   score      out  saturating score
//   hit_pulse  out  one-cycle pulse on a scored hit
//   miss_pulse out  one-cycle pulse on a missed press
module press_game_ctrl #(
    parameter int NUM_POS      = 4,
    parameter int POS_W        = 3,
    parameter int SCORE_W      = 8,
    parameter int SWEEP_BOUNCE = 1,
    parameter int MISS_PENALTY = 0
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   tick,
    input  logic                   hit_n,
    input  logic [7:0]             rng,
    press_game_ctrl_if.master      draw,
    output logic [POS_W-1:0]       press_pos,
    output logic                   garb_valid,
    output logic [POS_W-1:0]       garb_pos,
    output logic [SCORE_W-1:0]     score,
    output logic                   hit_pulse,
    output logic                   miss_pulse
);

    localparam logic [POS_W-1:0]   LAST_POS = POS_W'(NUM_POS - 1);
    localparam logic [POS_W-1:0]   POS_ONE  = POS_W'(1);
    localparam logic [SCORE_W-1:0] SC_ONE   = SCORE_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_PRESS_DRAW} state_t;
    // Which job is in flight, so the ack knows what comes next.
    typedef enum logic [1:0] {J_GERASE, J_GDRAW, J_PERASE, J_PDRAW} job_t;

    state_t           state;
    job_t             job;
    logic             dir_up;
    logic             hit_n_q;
    logic             pend_press;
    logic             pend_gerase;
    logic             pend_gdraw;
    logic             drawn_valid;
    logic [POS_W-1:0] drawn_pos;
    logic [POS_W-1:0] erase_pos;

    logic press_evt;
    logic hit;
    logic spawn;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SC_ONE;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
        return (v == '0) ? v : v - SC_ONE;
    endfunction

    // All decisions use start-of-cycle values, so a tick in the same cycle
    // as a press is judged against the pre-tick press position.
    assign press_evt = hit_n_q & ~hit_n;
    assign hit       = press_evt & garb_valid & (garb_pos == press_pos);
    // hit implies garb_valid, so a hit and a tick together never spawn.
    assign spawn     = tick & ~garb_valid & ~pend_gerase;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            job             <= J_PDRAW;
            dir_up          <= 1'b1;
            hit_n_q         <= 1'b1;
            pend_press      <= 1'b1;
            pend_gerase     <= 1'b0;
            pend_gdraw      <= 1'b0;
            drawn_valid     <= 1'b0;
            drawn_pos       <= '0;
            erase_pos       <= '0;
            press_pos       <= '0;
            garb_valid      <= 1'b0;
            garb_pos        <= '0;
            score           <= '0;
            hit_pulse       <= 1'b0;
            miss_pulse      <= 1'b0;
            draw.draw_req   <= 1'b0;
            draw.draw_item  <= 1'b0;
            draw.draw_erase <= 1'b0;
            draw.draw_pos   <= '0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            hit_n_q    <= hit_n;

            // Draw sequencer. Job fields are loaded on entry to ISSUE and
            // stay untouched until the ack, so they are stable under draw_req.
            case (state)
                S_IDLE: begin
                    if (pend_gerase) begin
                        job             <= J_GERASE;
                        draw.draw_item  <= 1'b0;
                        draw.draw_erase <= 1'b1;
                        draw.draw_pos   <= erase_pos;
                        pend_gerase     <= 1'b0;
                        state           <= S_ISSUE;
                    end else if (pend_gdraw) begin
                        job             <= J_GDRAW;
                        draw.draw_item  <= 1'b0;
                        draw.draw_erase <= 1'b0;
                        draw.draw_pos   <= garb_pos;
                        pend_gdraw      <= 1'b0;
                        state           <= S_ISSUE;
                    end else if (pend_press) begin
                        draw.draw_item <= 1'b1;
                        if (drawn_valid) begin
                            job             <= J_PERASE;
                            draw.draw_erase <= 1'b1;
                            draw.draw_pos   <= drawn_pos;
                        end else begin
                            job             <= J_PDRAW;
                            draw.draw_erase <= 1'b0;
                            draw.draw_pos   <= press_pos;
                            pend_press      <= 1'b0;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    draw.draw_req <= 1'b1;
                    state         <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (draw.draw_ack) begin
                        draw.draw_req <= 1'b0;
                        if (job == J_PERASE) begin
                            state <= S_PRESS_DRAW;
                        end else begin
                            state <= S_IDLE;
                            if (job == J_PDRAW) begin
                                drawn_pos   <= draw.draw_pos;
                                drawn_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_PRESS_DRAW: begin
                    // Latest press position wins; ticks during the erase merge here.
                    job             <= J_PDRAW;
                    draw.draw_item  <= 1'b1;
                    draw.draw_erase <= 1'b0;
                    draw.draw_pos   <= press_pos;
                    pend_press      <= 1'b0;
                    state           <= S_ISSUE;
                end
                default: state <= S_IDLE;
            endcase

            // Game rules come after the sequencer so a new request raised in
            // the same cycle as a clear is not lost.
            if (tick) begin
                pend_press <= 1'b1;
                if (NUM_POS > 1) begin
                    if (SWEEP_BOUNCE != 0) begin
                        if (dir_up) begin
                            if (press_pos == LAST_POS) begin
                                press_pos <= press_pos - POS_ONE;
                                dir_up    <= 1'b0;
                            end else begin
                                press_pos <= press_pos + POS_ONE;
                            end
                        end else if (press_pos == '0) begin
                            press_pos <= press_pos + POS_ONE;
                            dir_up    <= 1'b1;
                        end else begin
                            press_pos <= press_pos - POS_ONE;
                        end
                    end else begin
                        press_pos <= (press_pos == LAST_POS) ? '0 : press_pos + POS_ONE;
                    end
                end
            end

            if (press_evt) begin
                if (hit) begin
                    garb_valid  <= 1'b0;
                    score       <= sat_inc(score);
                    hit_pulse   <= 1'b1;
                    pend_gerase <= 1'b1;
                    erase_pos   <= garb_pos;
                    // A garbage draw not yet issued is dropped.
                    pend_gdraw  <= 1'b0;
                end else begin
                    miss_pulse <= 1'b1;
                    if (MISS_PENALTY != 0) begin
                        score <= sat_dec(score);
                    end
                end
            end

            if (spawn) begin
                garb_pos   <= POS_W'(32'(rng) % NUM_POS);
                garb_valid <= 1'b1;
                pend_gdraw <= 1'b1;
            end
        end
    end

endmodule
